replica_sequencer: RTL and testbench

Top-level run controller for the replica-exchange salesman array. It replaces host-driven pulsing of `set_random`, `opt_run`/`opt_com` and `exchange_valid` with an autonomous loop. The loop optionally seeds the per-replica RNG shift chain, then issues a configured number of optimisation steps, and inserts a replica-exchange step every `exch_interval` steps. It sits between the host register file and the replica array top, and drives those array inputs directly.

---
 rtl/replica_pkg.sv | 23 ++
 rtl/seq_wait_timer.sv | 29 ++
 rtl/replica_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_replica_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
// Shared types and constants for the replica-exchange array and its run sequencer.
package replica_pkg;

   typedef logic [3:0] opt_command_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEED      = 3'd1,
      ST_SEED_WAIT = 3'd2,
      ST_OPT       = 3'd3,
      ST_OPT_WAIT  = 3'd4,
      ST_EXCH      = 3'd5,
      ST_EXCH_WAIT = 3'd6,
      ST_FIN       = 3'd7
   } seq_state_t;

   localparam int unsigned EXCH_WAIT_CYCLES = 4;

   function automatic int unsigned max_one(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Load/count-down timer; o_expire marks the last cycle of an N-cycle wait loaded just before it.
module seq_wait_timer #(
   parameter int unsigned W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expire
);

   logic [W-1:0] r_cnt;

   // Count register: reload on i_load, otherwise count down to zero and rest there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/replica_sequencer.sv
// Autonomous run controller: optional RNG seeding, N optimisation steps, periodic exchanges.
module replica_sequencer
   import replica_pkg::*;
#(
   parameter int unsigned replica_num = 32,
   parameter int unsigned iter_w      = 24,
   parameter int unsigned wait_w      = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              seed_en,
   input  logic [iter_w-1:0] iter_num,
   input  opt_command_t      opt_com_cfg,
   input  logic [wait_w-1:0] opt_wait,
   input  logic [7:0]        exch_interval,
   output logic              busy,
   output logic              done,
   output logic [iter_w-1:0] iter_cnt,
   output logic              set_random,
   output logic              opt_run,
   output opt_command_t      opt_com,
   output logic              exchange_valid
);

   localparam int unsigned SEED_W = $clog2(replica_num + 1);
   localparam int unsigned TW0    = (wait_w > SEED_W) ? wait_w : SEED_W;
   localparam int unsigned TW     = (TW0 > 3) ? TW0 : 3;
   localparam logic [TW-1:0] SEED_LEN = TW'(max_one(replica_num));
   localparam logic [TW-1:0] EXCH_LEN = TW'(EXCH_WAIT_CYCLES);

   seq_state_t        r_state, w_state_nx;
   logic [iter_w-1:0] r_iter_num, r_iter_cnt, w_iter_cnt_nx, w_iter_inc;
   logic [wait_w-1:0] r_opt_wait;
   logic [7:0]        r_exch_interval, r_exch_cnt, w_exch_cnt_nx, w_exch_inc;
   opt_command_t      r_opt_com_cfg, r_opt_com, w_opt_com_nx;
   logic              r_busy, r_done, r_set_random, r_opt_run, r_exchange_valid;
   logic              w_latch, w_load, w_expire;
   logic [TW-1:0]     w_load_val, w_opt_len;

   assign w_iter_inc = r_iter_cnt + iter_w'(1);
   assign w_exch_inc = r_exch_cnt + 8'd1;
   assign w_opt_len  = (r_opt_wait == '0) ? TW'(1) : TW'(r_opt_wait);

   seq_wait_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst_n      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_expire   (w_expire)
   );

   // Next-state, counter update and timer-load decode; abort pre-empts every busy state but FIN.
   always_comb begin
      w_state_nx    = r_state;
      w_iter_cnt_nx = r_iter_cnt;
      w_exch_cnt_nx = r_exch_cnt;
      w_latch       = 1'b0;
      w_load        = 1'b0;
      w_load_val    = '0;
      w_opt_com_nx  = r_opt_com;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_latch       = 1'b1;
               w_iter_cnt_nx = '0;
               w_exch_cnt_nx = 8'd0;
               if (iter_num == '0) begin
                  w_state_nx = ST_FIN;
               end else if (seed_en) begin
                  w_state_nx = ST_SEED;
               end else begin
                  w_state_nx = ST_OPT;
               end
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_SEED: begin
            if (abort) begin
               w_state_nx = ST_FIN;
            end else begin
               w_load     = 1'b1;
               w_load_val = SEED_LEN;
               w_state_nx = ST_SEED_WAIT;
            end
         end
         ST_SEED_WAIT: begin
            if (abort) begin
               w_state_nx = ST_FIN;
            end else if (w_expire) begin
               w_state_nx = ST_OPT;
            end else begin
               w_state_nx = ST_SEED_WAIT;
            end
         end
         ST_OPT: begin
            if (abort) begin
               w_state_nx = ST_FIN;
            end else begin
               w_load     = 1'b1;
               w_load_val = w_opt_len;
               w_state_nx = ST_OPT_WAIT;
            end
         end
         ST_OPT_WAIT: begin
            if (abort) begin
               w_state_nx = ST_FIN;
            end else if (w_expire) begin
               w_iter_cnt_nx = w_iter_inc;
               w_exch_cnt_nx = w_exch_inc;
               if ((r_exch_interval != 8'd0) && (w_exch_inc == r_exch_interval)) begin
                  w_exch_cnt_nx = 8'd0;
                  w_state_nx    = ST_EXCH;
               end else if (w_iter_inc == r_iter_num) begin
                  w_state_nx = ST_FIN;
               end else begin
                  w_state_nx = ST_OPT;
               end
            end else begin
               w_state_nx = ST_OPT_WAIT;
            end
         end
         ST_EXCH: begin
            if (abort) begin
               w_state_nx = ST_FIN;
            end else begin
               w_load     = 1'b1;
               w_load_val = EXCH_LEN;
               w_state_nx = ST_EXCH_WAIT;
            end
         end
         ST_EXCH_WAIT: begin
            if (abort) begin
               w_state_nx = ST_FIN;
            end else if (w_expire) begin
               w_state_nx = (r_iter_cnt == r_iter_num) ? ST_FIN : ST_OPT;
            end else begin
               w_state_nx = ST_EXCH_WAIT;
            end
         end
         ST_FIN: begin
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
      // First step of a run must use the live cfg, since the latch lands on the same edge.
      if (w_state_nx == ST_OPT) begin
         if (r_state == ST_IDLE) begin
            w_opt_com_nx = opt_com_cfg;
         end else begin
            w_opt_com_nx = r_opt_com_cfg;
         end
      end else begin
         w_opt_com_nx = r_opt_com;
      end
   end

   // State, counters and Moore outputs, all decoded from the next state so they align with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= ST_IDLE;
         r_iter_cnt       <= '0;
         r_exch_cnt       <= 8'd0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_set_random     <= 1'b0;
         r_opt_run        <= 1'b0;
         r_exchange_valid <= 1'b0;
         r_opt_com        <= '0;
      end else begin
         r_state          <= w_state_nx;
         r_iter_cnt       <= w_iter_cnt_nx;
         r_exch_cnt       <= w_exch_cnt_nx;
         r_busy           <= (w_state_nx != ST_IDLE);
         r_done           <= (w_state_nx == ST_FIN);
         r_set_random     <= (w_state_nx == ST_SEED);
         r_opt_run        <= (w_state_nx == ST_OPT);
         r_exchange_valid <= (w_state_nx == ST_EXCH);
         r_opt_com        <= w_opt_com_nx;
      end
   end

   // Run configuration, captured only when a start is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_iter_num      <= '0;
         r_opt_wait      <= '0;
         r_exch_interval <= 8'd0;
         r_opt_com_cfg   <= '0;
      end else if (w_latch) begin
         r_iter_num      <= iter_num;
         r_opt_wait      <= opt_wait;
         r_exch_interval <= exch_interval;
         r_opt_com_cfg   <= opt_com_cfg;
      end else begin
         r_iter_num      <= r_iter_num;
         r_opt_wait      <= r_opt_wait;
         r_exch_interval <= r_exch_interval;
         r_opt_com_cfg   <= r_opt_com_cfg;
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign iter_cnt       = r_iter_cnt;
   assign set_random     = r_set_random;
   assign opt_run        = r_opt_run;
   assign opt_com        = r_opt_com;
   assign exchange_valid = r_exchange_valid;

endmodule

// File: tb/tb_replica_sequencer.sv
// Self-checking bench for replica_sequencer: a cycle timeline model derived from the run rules.
module tb_replica_sequencer;
   import replica_pkg::*;

   localparam int RN   = 32;
   localparam int IW   = 24;
   localparam int WW   = 12;
   localparam int MAXC = 600;

   logic         clk = 1'b0;
   logic         reset, start, abort, seed_en;
   logic [IW-1:0] iter_num;
   opt_command_t opt_com_cfg;
   logic [WW-1:0] opt_wait;
   logic [7:0]   exch_interval;
   logic         busy, done, set_random, opt_run, exchange_valid;
   logic [IW-1:0] iter_cnt;
   opt_command_t opt_com;

   int n_checks = 0;
   int n_errors = 0;
   int last_cnt = 0;
   opt_command_t last_com = '0;

   bit e_sr [MAXC];
   bit e_opt [MAXC];
   bit e_ex [MAXC];
   bit e_done [MAXC];
   bit e_busy [MAXC];
   int e_cnt [MAXC];
   opt_command_t e_com [MAXC];

   replica_sequencer #(.replica_num(RN), .iter_w(IW), .wait_w(WW)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .seed_en        (seed_en),
      .iter_num       (iter_num),
      .opt_com_cfg    (opt_com_cfg),
      .opt_wait       (opt_wait),
      .exch_interval  (exch_interval),
      .busy           (busy),
      .done           (done),
      .iter_cnt       (iter_cnt),
      .set_random     (set_random),
      .opt_run        (opt_run),
      .opt_com        (opt_com),
      .exchange_valid (exchange_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, -1, 32'(busy), 32'd0);
      chk({tag, "_done"}, -1, 32'(done), 32'd0);
      chk({tag, "_set_random"}, -1, 32'(set_random), 32'd0);
      chk({tag, "_opt_run"}, -1, 32'(opt_run), 32'd0);
      chk({tag, "_exchange_valid"}, -1, 32'(exchange_valid), 32'd0);
      chk({tag, "_iter_cnt"}, -1, 32'(iter_cnt), 32'd0);
      chk({tag, "_opt_com"}, -1, 32'(opt_com), 32'd0);
   endtask

   // Timeline model: cycle 0 is the cycle start is high; events follow the step/exchange periods.
   task automatic build(input bit seed, input int iter, input int w, input int ivl,
                        input opt_command_t com, input int abort_at, output int done_c);
      int t;
      int wend[$];
      bit aborted;
      opt_command_t c;
      for (int n = 0; n < MAXC; n++) begin
         e_sr[n] = 0; e_opt[n] = 0; e_ex[n] = 0; e_done[n] = 0; e_busy[n] = 0; e_cnt[n] = 0;
      end
      t = 1;
      if (iter == 0) begin
         done_c = 1;
      end else begin
         if (seed) begin
            e_sr[1] = 1;
            t = 2 + RN;
         end
         for (int i = 1; i <= iter; i++) begin
            e_opt[t] = 1;
            t = t + 1 + ((w == 0) ? 1 : w);
            wend.push_back(t - 1);
            if (ivl != 0 && (i % ivl) == 0) begin
               e_ex[t] = 1;
               t = t + 1 + int'(EXCH_WAIT_CYCLES);
            end
         end
         done_c = t;
      end
      aborted = (abort_at > 0) && (abort_at < done_c);
      if (aborted) begin
         for (int n = abort_at + 1; n < MAXC; n++) begin
            e_sr[n] = 0; e_opt[n] = 0; e_ex[n] = 0;
         end
         done_c = abort_at + 1;
      end
      e_done[done_c] = 1;
      for (int n = 1; n <= done_c; n++) e_busy[n] = 1;
      e_cnt[0] = last_cnt;
      for (int n = 1; n < MAXC; n++) begin
         int k = 0;
         foreach (wend[j]) if (wend[j] < n && (!aborted || wend[j] < abort_at)) k++;
         e_cnt[n] = k;
      end
      c = last_com;
      for (int n = 0; n < MAXC; n++) begin
         if (e_opt[n]) c = com;
         e_com[n] = c;
      end
   endtask

   task automatic run(input bit seed, input int iter, input int w, input int ivl,
                      input opt_command_t com, input int abort_at, input bit poke);
      int done_c, end_c;
      build(seed, iter, w, ivl, com, abort_at, done_c);
      end_c = done_c + 2;
      @(posedge clk); #1;
      start = 1'b1; seed_en = seed; iter_num = IW'(iter); opt_wait = WW'(w);
      exch_interval = 8'(ivl); opt_com_cfg = com; abort = (abort_at == 0);
      for (int n = 0; n <= end_c; n++) begin
         @(negedge clk);
         chk("busy", n, 32'(busy), 32'(e_busy[n]));
         chk("done", n, 32'(done), 32'(e_done[n]));
         chk("set_random", n, 32'(set_random), 32'(e_sr[n]));
         chk("opt_run", n, 32'(opt_run), 32'(e_opt[n]));
         chk("exchange_valid", n, 32'(exchange_valid), 32'(e_ex[n]));
         chk("iter_cnt", n, 32'(iter_cnt), 32'(e_cnt[n]));
         chk("opt_com", n, 32'(opt_com), 32'(e_com[n]));
         @(posedge clk); #1;
         start = 1'b0;
         abort = ((n + 1) == abort_at);
         if (poke && (n + 1) <= done_c) begin
            start = 1'($urandom_range(0, 1));
            seed_en = 1'($urandom_range(0, 1));
            iter_num = IW'($urandom_range(0, 20));
            opt_wait = WW'($urandom_range(0, 9));
            exch_interval = 8'($urandom_range(0, 3));
            opt_com_cfg = opt_command_t'($urandom_range(0, 15));
         end
      end
      start = 1'b0;
      abort = 1'b0;
      last_cnt = e_cnt[end_c];
      last_com = e_com[end_c];
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; seed_en = 1'b0;
      iter_num = '0; opt_com_cfg = '0; opt_wait = '0; exch_interval = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // Reset in the middle of an opt wait.
      @(posedge clk); #1;
      start = 1'b1; seed_en = 1'b0; iter_num = IW'(10); opt_wait = WW'(5);
      exch_interval = 8'd0; opt_com_cfg = 4'hC;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("pre_reset_opt_run", 1, 32'(opt_run), 32'd1);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(negedge clk);
      chk_all_zero("reset_held");
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_all_zero("post_reset");
      end
      last_cnt = 0;
      last_com = '0;

      run(1'b1, 3, 5, 0, 4'hA, -1, 1'b0);
      run(1'b0, 4, 2, 2, 4'h5, -1, 1'b0);
      run(1'b0, 0, 3, 1, 4'h3, -1, 1'b0);
      run(1'b0, 10, 3, 0, 4'h7, 7, 1'b0);
      run(1'b0, 5, 1, 0, 4'h9, -1, 1'b1);
      run(1'b0, 3, 0, 3, 4'h6, 0, 1'b0);
      run(1'b1, 2, 1, 1, 4'hE, 15, 1'b0);

      for (int k = 0; k < 12; k++) begin
         int ab;
         ab = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 40));
         run(1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 3)), opt_command_t'($urandom_range(0, 15)), ab,
             1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
